fifo_cts_receiver: RTL and testbench

//  Receiving end of the router-to-router RTS/CTS link. The upstream arbiter drives RTS (our DRTS) and samples our CTS (its DCTS).

---
 rtl/fifo_cts_receiver.sv | 119 +++++++++++
 tb/tb_fifo_cts_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_cts_receiver.sv
// fifo_cts_receiver
// Receiving end of a router-to-router RTS/CTS link. Each handshake
// accepts one flit into a small circular FIFO, and the head flit is
// presented to the local crossbar with first-word fall-through. Any of
// the five output arbiters may pop the head through its read_en line.

module fifo_cts_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cts_state_t;

    cts_state_t             state_q;
    cts_state_t             state_d;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_d;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [DEPTH];

    logic write_en;
    logic read_req;
    logic read_en;

    // CTS follows the state register directly, so it is a clean registered pulse.
    assign CTS      = (state_q == ACK);
    assign write_en = DRTS & CTS;
    assign read_req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    assign read_en  = read_req & ~empty;

    assign Data_out = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);

    // Handshake next state: grant only from IDLE when there is room, then always drop back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (DRTS && !full) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage, pointer and occupancy updates for the current write/pop pair.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (write_en) begin
            mem_d[wr_ptr_q] = RX;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (read_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({write_en, read_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; reset wipes storage so Data_out reads zero and drops any pending grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_cts_receiver.sv
// tb_fifo_cts_receiver
// Directed scenarios with hand-computed expectations, followed by a long
// randomized run. A behavioural model (a write/pop count plus a shadow
// ring of flits) predicts CTS, empty, full and Data_out on every cycle.

module tb_fifo_cts_receiver;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] RX = '0;
    logic          DRTS = 1'b0;
    logic          read_en_N = 1'b0;
    logic          read_en_E = 1'b0;
    logic          read_en_W = 1'b0;
    logic          read_en_S = 1'b0;
    logic          read_en_L = 1'b0;
    logic          CTS;
    logic [DW-1:0] Data_out;
    logic          empty;
    logic          full;

    int total = 0;
    int bad   = 0;

    fifo_cts_receiver #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .RX(RX),
        .DRTS(DRTS),
        .read_en_N(read_en_N),
        .read_en_E(read_en_E),
        .read_en_W(read_en_W),
        .read_en_S(read_en_S),
        .read_en_L(read_en_L),
        .CTS(CTS),
        .Data_out(Data_out),
        .empty(empty),
        .full(full)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy is writes minus pops; the flit ring is indexed by those totals.
    logic          m_cts = 1'b0;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_writes = 0;
    int            m_pops = 0;
    bit            checkOn = 1'b0;
    int            m_size;
    bit            m_wr;
    bit            m_pop;
    bit            m_next;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic boundExpired(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired, got no event expected one", name);
    endtask

    task automatic applyStimulus(input bit drts, input logic [DW-1:0] rx, input logic [4:0] rd);
        @(posedge clk);
        #1;
        DRTS = drts;
        RX   = rx;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = rd;
    endtask

    // Model advances on every active edge using the inputs the DUT also sees.
    always @(posedge clk) begin
        if (rst) begin
            m_cts    = 1'b0;
            m_writes = 0;
            m_pops   = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            checkOn  = 1'b1;
        end else begin
            m_size = m_writes - m_pops;
            m_wr   = DRTS && m_cts;
            m_pop  = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) && (m_size > 0);
            m_next = !m_cts && DRTS && (m_size < DEPTH);
            if (m_wr) begin
                m_mem[m_writes % DEPTH] = RX;
                m_writes++;
            end
            if (m_pop) m_pops++;
            m_cts = m_next;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("cts", {31'd0, CTS}, {31'd0, m_cts});
            checkOutput("empty", {31'd0, empty}, {31'd0, (m_writes - m_pops) == 0});
            checkOutput("full", {31'd0, full}, {31'd0, (m_writes - m_pops) == DEPTH});
            checkOutput("data_out", Data_out, m_mem[m_pops % DEPTH]);
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        DRTS = 1'b0;
        RX   = '0;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_cts", {31'd0, CTS}, 32'd0);
        checkOutput("rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_data", Data_out, 32'd0);
        rst = 1'b0;
    endtask

    task automatic writeFlit(input logic [DW-1:0] v);
        int w0;
        bit done;
        w0   = m_writes;
        done = 1'b0;
        applyStimulus(1'b1, v, 5'b0);
        for (int i = 0; i < 8 && !done; i++) begin
            applyStimulus(1'b1, v, 5'b0);
            if (m_writes != w0) done = 1'b1;
        end
        if (!done) boundExpired("write_flit");
        DRTS = 1'b0;
        RX   = '0;
    endtask

    task automatic popOnce(input logic [4:0] rd);
        applyStimulus(1'b0, '0, rd);
        applyStimulus(1'b0, '0, 5'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int pulses;
        bit got;
        logic [4:0] rd;

        // T1 reset
        doReset();

        // T2 single flit
        applyStimulus(1'b1, 32'hA5A5_0001, 5'b0);
        applyStimulus(1'b1, 32'hA5A5_0001, 5'b0);
        checkOutput("t2_cts_high", {31'd0, CTS}, 32'd1);
        applyStimulus(1'b0, '0, 5'b0);
        checkOutput("t2_cts_low", {31'd0, CTS}, 32'd0);
        checkOutput("t2_empty", {31'd0, empty}, 32'd0);
        checkOutput("t2_data", Data_out, 32'hA5A5_0001);

        // T3 fill with DRTS held high
        doReset();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, DW'(m_writes + 1), 5'b0);
            if (CTS) pulses++;
        end
        DRTS = 1'b0;
        checkOutput("t3_pulses", DW'(pulses), 32'd4);
        checkOutput("t3_full", {31'd0, full}, 32'd1);
        checkOutput("t3_data", Data_out, 32'd1);

        // T4 drain through East, then wrap with three more flits
        for (int k = 1; k <= 4; k++) begin
            checkOutput("t4_head", Data_out, DW'(k));
            popOnce(5'b01000);
        end
        checkOutput("t4_empty", {31'd0, empty}, 32'd1);
        writeFlit(32'd5);
        writeFlit(32'd6);
        writeFlit(32'd7);
        checkOutput("t4_wrap_data", Data_out, 32'd5);

        // T5 write of flit 9 lands on the same edge as a Local pop
        popOnce(5'b0);
        applyStimulus(1'b1, 32'd9, 5'b0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (m_cts) got = 1'b1;
            else applyStimulus(1'b1, 32'd9, 5'b0);
        end
        if (!got) boundExpired("t5_cts");
        read_en_L = 1'b1;
        applyStimulus(1'b0, '0, 5'b0);
        checkOutput("t5_full", {31'd0, full}, 32'd0);
        checkOutput("t5_empty", {31'd0, empty}, 32'd0);
        checkOutput("t5_head", Data_out, 32'd6);
        popOnce(5'b00001);
        checkOutput("t5_head2", Data_out, 32'd7);
        popOnce(5'b00001);
        checkOutput("t5_tail", Data_out, 32'd9);
        popOnce(5'b00001);
        checkOutput("t5_drained", {31'd0, empty}, 32'd1);

        // T6 dual pop on empty, then reset while CTS is high
        doReset();
        popOnce(5'b10010);
        checkOutput("t6_empty", {31'd0, empty}, 32'd1);
        checkOutput("t6_data", Data_out, 32'd0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 5'b0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            applyStimulus(1'b1, 32'hDEAD_BEEF, 5'b0);
            if (CTS) got = 1'b1;
        end
        if (!got) boundExpired("t6_cts");
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_rst_cts", {31'd0, CTS}, 32'd0);
        checkOutput("t6_rst_empty", {31'd0, empty}, 32'd1);
        rst  = 1'b0;
        DRTS = 1'b0;
        applyStimulus(1'b0, '0, 5'b0);
        checkOutput("t6_not_stored", {31'd0, empty}, 32'd1);
        checkOutput("t6_data_zero", Data_out, 32'd0);

        // Randomized run: phases with light and heavy read traffic, rare resets
        for (int c = 0; c < 3000; c++) begin
            if (((c / 250) % 2) == 0)
                rd = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
            else
                rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
            applyStimulus($urandom_range(0, 99) < 65, DW'($urandom), rd);
            rst = ($urandom_range(0, 299) == 0);
        end
        applyStimulus(1'b0, '0, 5'b0);
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, '0, 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
